// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder.
//   state_t       : controller state encodings (IDLE/RUN/DONE)
//   DEF_N         : default slice width in bits
//   DEF_WORDS     : default number of slices per operand
package multiword_add_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEF_N     = 16;
   localparam int DEF_WORDS = 4;

endpackage

// File: rtl/multiword_add_seq_fulladderNb.sv
// N-bit ripple-carry adder used for one slice of the wide add.
// Ports:
//   a, b  in  N  slice operands
//   cin   in  1  carry into bit 0
//   sum   out N  slice sum
//   cout  out 1  carry out of bit N-1
module fulladderNb #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: {cout,sum} = a + b + cin over WORDS cycles using one
// N-bit ripple adder whose carry-out is recirculated into the next slice.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for operands; in_ready high, last result held
//   RUN    | one slice added per cycle, WORDS cycles in total
//   DONE   | result presented on out_valid until out_ready
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  can accept an operation (IDLE only)
//   a, b       in   W  operands, captured on accept
//   cin        in   1  carry into slice 0, captured on accept
//   out_valid  out  1  result valid (DONE only)
//   out_ready  in   1  consumer takes result
//   sum        out  W  registered a+b+cin modulo 2^W
//   cout       out  1  registered carry out of top slice
//   busy       out  1  high in RUN or DONE
module multiword_add_seq
   import multiword_add_seq_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WORDS = DEF_WORDS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*WORDS-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int W  = N * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

   state_t          state_q, state_d;
   logic [W-1:0]    a_sh_q, a_sh_d;
   logic [W-1:0]    b_sh_q, b_sh_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [N-1:0]    add_sum;
   logic            add_cout;
   logic [W-1:0]    sum_shift;

   fulladderNb #(.N(N)) u_slice_add (
      .a    (a_sh_q[N-1:0]),
      .b    (b_sh_q[N-1:0]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // New slice sums enter at the top so that after WORDS shifts slice 0 sits
   // at the bottom; with a single slice there is nothing to shift.
   if (WORDS == 1) begin : g_one
      assign sum_shift = add_sum;
   end else begin : g_multi
      assign sum_shift = {add_sum, sum_q[W-1:N]};
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d  = a_sh_q >> N;
            b_sh_d  = b_sh_q >> N;
            sum_d   = sum_shift;
            carry_d = add_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

   localparam int N     = 16;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [W-1:0]  a, b, sum;

   logic          in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
   logic [N-1:0]  a1, b1, sum1;

   always #5 clk = ~clk;

   multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   multiword_add_seq #(.N(N), .WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [W:0]   exp_q[$];
   bit           stall_en = 0;

   function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: a result is consumed on the edge after a negedge
   // that sees out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin : pop
         logic [W:0] e;
         if (exp_q.size() == 0) begin
            chk("spurious_result", (W+1)'(out_valid), (W+1)'(0));
         end else begin
            e = exp_q.pop_front();
            chk("result", {cout, sum}, e);
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W:0] ex, input bit push);
      int guard;
      guard = 0;
      a = ia; b = ib; cin = ic; in_valid = 1'b1;
      while (!in_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         chk("accept_timeout", (W+1)'(in_ready), (W+1)'(1));
         in_valid = 1'b0;
      end else begin
         if (push) exp_q.push_back(ex);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || !in_ready) && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 300) begin
         chk("drain_queue", (W+1)'(exp_q.size()), (W+1)'(0));
         chk("drain_in_ready", (W+1)'(in_ready), (W+1)'(1));
      end
   endtask

   task automatic run1(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                       input logic [N:0] ex);
      chk("w1_in_ready", (W+1)'(in_ready1), (W+1)'(1));
      a1 = ia; b1 = ib; cin1 = ic; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("w1_latency_low", (W+1)'(out_valid1), (W+1)'(0));
      @(negedge clk);
      chk("w1_latency_high", (W+1)'(out_valid1), (W+1)'(1));
      chk("w1_result", (W+1)'({cout1, sum1}), (W+1)'(ex));
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a1 = '0; b1 = '0; cin1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;

      #1;
      chk("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
      chk("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
      chk("rst_busy", (W+1)'(busy), (W+1)'(0));
      chk("rst_result", {cout, sum}, (W+1)'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: carry from slice 0 into slice 1, latency check
      issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 65'h0_0000_0000_0001_0000, 1);
      for (int i = 0; i < WORDS; i++) begin
         @(negedge clk);
         chk("t1_latency_low", (W+1)'(out_valid), (W+1)'(0));
      end
      @(negedge clk);
      chk("t1_latency_high", (W+1)'(out_valid), (W+1)'(1));
      chk("t1_busy_done", (W+1)'(busy), (W+1)'(1));
      chk("t1_in_ready_done", (W+1)'(in_ready), (W+1)'(0));
      wait_drain();

      // 2, 3: full carry propagation
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1);
      wait_drain();
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 65'h1_0000_0000_0000_0000, 1);
      wait_drain();

      // 4: stall in DONE, new operands must be ignored
      out_ready = 1'b0;
      issue(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 65'h1_0000_0000_0000_0002, 1);
      begin : wait_done
         int guard;
         guard = 0;
         while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         chk("t4_reach_done", (W+1)'(out_valid), (W+1)'(1));
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            a = 64'h0000_0000_0000_0005; b = 64'h0000_0000_0000_0007; cin = 1'b1; in_valid = 1'b1;
         end
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
         chk("t4_hold_result", {cout, sum}, 65'h1_0000_0000_0000_0002);
         chk("t4_hold_valid", (W+1)'(out_valid), (W+1)'(1));
         chk("t4_in_ready_low", (W+1)'(in_ready), (W+1)'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();
      chk("t4_idle_retain", {cout, sum}, 65'h1_0000_0000_0000_0002);
      chk("t4_idle_busy", (W+1)'(busy), (W+1)'(0));

      // 5: asynchronous reset in the 2nd RUN cycle abandons the op
      issue(64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 1'b0, '0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_in_ready", (W+1)'(in_ready), (W+1)'(1));
      chk("t5_out_valid", (W+1)'(out_valid), (W+1)'(0));
      chk("t5_busy", (W+1)'(busy), (W+1)'(0));
      chk("t5_result_clear", {cout, sum}, (W+1)'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(64'h1, 64'h2, 1'b0, 65'h3, 1);
      wait_drain();

      // 6: back-to-back ops with random consumer stalls
      stall_en = 1;
      fork
         begin
            for (int k = 0; k < 200; k++) begin
               if (k % 8 == 0) begin
                  ra = '1; rb = '0; rc = 1'b1;
               end else begin
                  ra = {$urandom, $urandom};
                  rb = {$urandom, $urandom};
                  rc = 1'($urandom_range(0, 1));
               end
               issue(ra, rb, rc, golden(ra, rb, rc), 1);
            end
            stall_en = 0;
         end
         begin
            while (stall_en) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // WORDS = 1 instance: single RUN cycle
      run1(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
      run1(16'h1234, 16'h4321, 1'b1, 17'h0_5556);
      run1(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);

      chk("scoreboard_empty", (W+1)'(exp_q.size()), (W+1)'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
